// File: rtl/corner_extractor_pkg.sv
// Shared constants for the corner extractor: frame geometry, score/count widths,
// score offsets, corner indices in parameter-stage order and identity reset corners.
package corner_extractor_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int SCORE_W = 11;
    localparam int CNT_W   = 19;

    localparam logic [SCORE_W-1:0] S2_OFFSET = 11'd640;
    localparam logic [SCORE_W-1:0] S4_OFFSET = 11'd480;

    localparam int C_TOP_LEFT  = 1;
    localparam int C_BOT_LEFT  = 2;
    localparam int C_BOT_RIGHT = 3;
    localparam int C_TOP_RIGHT = 4;

    typedef enum logic {
        MODE_MIN = 1'b0,
        MODE_MAX = 1'b1
    } mode_e;

    // Packed [4:1]: leftmost element is corner 4.
    localparam logic [4:1][X_W-1:0] ID_X = {10'd639, 10'd639, 10'd0, 10'd0};
    localparam logic [4:1][Y_W-1:0] ID_Y = {9'd0, 9'd479, 9'd479, 9'd0};

endpackage

// File: rtl/corner_extractor_if.sv
// Pixel-stream inputs and latched corner outputs of the corner extractor.
// master drives the pixel stream, slave is the extractor.
interface corner_extractor_if;
    import corner_extractor_pkg::*;

    logic           pixel_valid;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           hit;
    logic           frame_end;
    logic           freeze;

    logic [X_W-1:0] x1, x2, x3, x4;
    logic [Y_W-1:0] y1, y2, y3, y4;
    logic           corners_valid;
    logic           corners_ok;

    modport master (
        output pixel_valid, x, y, hit, frame_end, freeze,
        input  x1, x2, x3, x4, y1, y2, y3, y4, corners_valid, corners_ok
    );

    modport slave (
        input  pixel_valid, x, y, hit, frame_end, freeze,
        output x1, x2, x3, x4, y1, y2, y3, y4, corners_valid, corners_ok
    );
endinterface

// File: rtl/corner_extractor_extremum.sv
// One extremal-pixel tracker; outputs are the post-edge (next-state) best x/y/seen so a
// pixel arriving together with clear is still part of the closing frame. No backpressure.
module corner_extremum
    import corner_extractor_pkg::*;
#(
    parameter mode_e MODE = MODE_MIN
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_en,
    input  logic [SCORE_W-1:0] i_score,
    input  logic [X_W-1:0]     i_x,
    input  logic [Y_W-1:0]     i_y,
    output logic [X_W-1:0]     o_best_x,
    output logic [Y_W-1:0]     o_best_y,
    output logic               o_seen
);
    logic [SCORE_W-1:0] r_score;
    logic [X_W-1:0]     r_x;
    logic [Y_W-1:0]     r_y;
    logic               r_seen;

    logic w_better;
    logic w_take;

    // Strict comparison: on a tie the earlier pixel in raster order stays.
    assign w_better = (MODE == MODE_MIN) ? (i_score < r_score) : (i_score > r_score);
    assign w_take   = i_en && (!r_seen || w_better);

    assign o_best_x = w_take ? i_x : r_x;
    assign o_best_y = w_take ? i_y : r_y;
    assign o_seen   = r_seen || i_en;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_seen  <= 1'b0;
            r_score <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else if (w_take) begin
            r_seen  <= 1'b1;
            r_score <= i_score;
            r_x     <= i_x;
            r_y     <= i_y;
        end
    end
endmodule

// File: rtl/corner_extractor.sv
// Tracks the four extremal marker pixels per frame and latches them as corners 1-4 one
// cycle after frame_end; one pixel per cycle, no backpressure.
module corner_extractor
    import corner_extractor_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int MIN_HITS = 64
) (
    input  logic               i_clk,
    input  logic               i_reset,
    corner_extractor_if.slave  io_bus
);
    localparam logic [X_W:0]       LP_H   = (X_W+1)'(H_ACTIVE);
    localparam logic [Y_W:0]       LP_V   = (Y_W+1)'(V_ACTIVE);
    localparam logic [CNT_W-1:0]   LP_MIN = CNT_W'(MIN_HITS);

    logic               w_qual;
    logic [SCORE_W-1:0] w_xe, w_ye;
    logic [SCORE_W-1:0] w_s    [1:4];
    logic [X_W-1:0]     w_bx   [1:4];
    logic [Y_W-1:0]     w_by   [1:4];
    logic               w_seen [1:4];
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_update;

    logic [CNT_W-1:0]     r_cnt;
    logic [4:1][X_W-1:0]  r_x;
    logic [4:1][Y_W-1:0]  r_y;
    logic                 r_valid;
    logic                 r_ok;

    assign w_qual = io_bus.pixel_valid && io_bus.hit &&
                    ({1'b0, io_bus.x} < LP_H) && ({1'b0, io_bus.y} < LP_V);

    assign w_xe = {1'b0, io_bus.x};
    assign w_ye = {2'b0, io_bus.y};

    // Offsets keep s2/s4 non-negative across the whole active area.
    assign w_s[C_TOP_LEFT]  = w_xe + w_ye;
    assign w_s[C_BOT_LEFT]  = w_ye + S2_OFFSET - w_xe;
    assign w_s[C_BOT_RIGHT] = w_xe + w_ye;
    assign w_s[C_TOP_RIGHT] = w_xe + S4_OFFSET - w_ye;

    for (genvar g = 1; g <= 4; g++) begin : g_trk
        corner_extremum #(
            .MODE ((g == C_TOP_LEFT) ? MODE_MIN : MODE_MAX)
        ) u_trk (
            .i_clk    (i_clk),
            .i_reset  (i_reset),
            .i_clear  (io_bus.frame_end),
            .i_en     (w_qual),
            .i_score  (w_s[g]),
            .i_x      (io_bus.x),
            .i_y      (io_bus.y),
            .o_best_x (w_bx[g]),
            .o_best_y (w_by[g]),
            .o_seen   (w_seen[g])
        );
    end

    assign w_cnt_nxt = (w_qual && (r_cnt != '1)) ? r_cnt + CNT_W'(1) : r_cnt;
    assign w_update  = io_bus.frame_end && (w_cnt_nxt >= LP_MIN) && !io_bus.freeze;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_ok    <= 1'b0;
            r_x     <= ID_X;
            r_y     <= ID_Y;
        end else begin
            r_valid <= io_bus.frame_end;
            r_cnt   <= io_bus.frame_end ? '0 : w_cnt_nxt;
            if (io_bus.frame_end) begin
                r_ok <= w_update;
            end
            for (int i = 1; i <= 4; i++) begin
                if (w_update && w_seen[i]) begin
                    r_x[i] <= w_bx[i];
                    r_y[i] <= w_by[i];
                end
            end
        end
    end

    assign io_bus.x1 = r_x[C_TOP_LEFT];
    assign io_bus.y1 = r_y[C_TOP_LEFT];
    assign io_bus.x2 = r_x[C_BOT_LEFT];
    assign io_bus.y2 = r_y[C_BOT_LEFT];
    assign io_bus.x3 = r_x[C_BOT_RIGHT];
    assign io_bus.y3 = r_y[C_BOT_RIGHT];
    assign io_bus.x4 = r_x[C_TOP_RIGHT];
    assign io_bus.y4 = r_y[C_TOP_RIGHT];
    assign io_bus.corners_valid = r_valid;
    assign io_bus.corners_ok    = r_ok;
endmodule

// File: tb/tb_corner_extractor.sv
// Randomized plus directed stimulus against a list-based reference model of the corner rules.
module tb_corner_extractor;
    localparam int MIN_HITS = 4;

    logic clk;
    logic rst;
    corner_extractor_if bus ();

    corner_extractor #(.H_ACTIVE(640), .V_ACTIVE(480), .MIN_HITS(MIN_HITS)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .io_bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the qualifying pixels of the open frame, in arrival order.
    int q_x[$];
    int q_y[$];
    int ex[1:4];
    int ey[1:4];
    bit e_ok;
    bit e_valid;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q_x.delete();
        q_y.delete();
        ex = '{0, 0, 639, 639};
        ey = '{0, 479, 479, 0};
        e_ok    = 1'b0;
        e_valid = 1'b0;
    endtask

    task automatic eval_frame(input bit frz);
        bit upd;
        upd = (q_x.size() >= MIN_HITS) && !frz;
        e_ok = upd;
        e_valid = 1'b1;
        if (upd) begin
            int b1, b2, b3, b4;
            b1 = 0; b2 = 0; b3 = 0; b4 = 0;
            for (int i = 1; i < q_x.size(); i++) begin
                if (q_x[i] + q_y[i] < q_x[b1] + q_y[b1]) b1 = i;
                if (q_y[i] - q_x[i] > q_y[b2] - q_x[b2]) b2 = i;
                if (q_x[i] + q_y[i] > q_x[b3] + q_y[b3]) b3 = i;
                if (q_x[i] - q_y[i] > q_x[b4] - q_y[b4]) b4 = i;
            end
            ex[1] = q_x[b1]; ey[1] = q_y[b1];
            ex[2] = q_x[b2]; ey[2] = q_y[b2];
            ex[3] = q_x[b3]; ey[3] = q_y[b3];
            ex[4] = q_x[b4]; ey[4] = q_y[b4];
        end
        q_x.delete();
        q_y.delete();
    endtask

    task automatic step(input bit r, input bit pv, input int px, input int py,
                        input bit ph, input bit fe, input bit fz);
        logic [79:0] got, exp;
        @(negedge clk);
        rst             = r;
        bus.pixel_valid = pv;
        bus.x           = 10'(px);
        bus.y           = 9'(py);
        bus.hit         = ph;
        bus.frame_end   = fe;
        bus.freeze      = fz;
        if (r) begin
            model_reset();
        end else begin
            e_valid = 1'b0;
            if (pv && ph && px < 640 && py < 480) begin
                q_x.push_back(px);
                q_y.push_back(py);
            end
            if (fe) eval_frame(fz);
        end
        @(posedge clk);
        #1;
        got = {4'b0, bus.x1, bus.y1, bus.x2, bus.y2, bus.x3, bus.y3, bus.x4, bus.y4};
        exp = {4'b0, 10'(ex[1]), 9'(ey[1]), 10'(ex[2]), 9'(ey[2]),
                     10'(ex[3]), 9'(ey[3]), 10'(ex[4]), 9'(ey[4])};
        chk("corners_valid", 80'(bus.corners_valid), 80'(e_valid));
        chk("corners_ok", 80'(bus.corners_ok), 80'(e_ok));
        chk("corners", got, exp);
    endtask

    task automatic hit_px(input int px, input int py);
        step(1'b0, 1'b1, px, py, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic end_frame(input bit fz);
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, fz);
    endtask

    initial begin
        model_reset();
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

        // Basic four-corner frame
        hit_px(100, 50); hit_px(80, 400); hit_px(600, 450); hit_px(620, 30);
        end_frame(1'b0);
        chk("basic_x1", 80'(bus.x1), 80'd100);
        chk("basic_y4", 80'(bus.y4), 80'd30);

        // Tie on s1 keeps the earlier pixel
        hit_px(20, 0); hit_px(10, 10); hit_px(300, 200); hit_px(310, 210); hit_px(320, 220);
        end_frame(1'b0);
        chk("tie_x1", 80'(bus.x1), 80'd20);
        chk("tie_y1", 80'(bus.y1), 80'd0);

        // Too few hits: held outputs
        hit_px(1, 1); hit_px(2, 2); hit_px(3, 3);
        end_frame(1'b0);

        // Hit coincident with frame_end is included; next cycle hit belongs to next frame
        hit_px(200, 200); hit_px(210, 100); hit_px(50, 300);
        step(1'b0, 1'b1, 639, 479, 1'b1, 1'b1, 1'b0);
        chk("fe_hit_x3", 80'(bus.x3), 80'd639);
        chk("fe_hit_y3", 80'(bus.y3), 80'd479);
        hit_px(5, 5); hit_px(400, 400); hit_px(401, 10); hit_px(30, 470);
        end_frame(1'b0);
        chk("next_x1", 80'(bus.x1), 80'd5);

        // Out-of-range hits are ignored
        hit_px(700, 100); hit_px(100, 500); hit_px(10, 10); hit_px(20, 20); hit_px(30, 30);
        end_frame(1'b0);
        chk("oor_ok", 80'(bus.corners_ok), 80'd0);

        // Freeze suppresses an otherwise valid update
        hit_px(11, 12); hit_px(13, 400); hit_px(500, 410); hit_px(520, 15);
        end_frame(1'b1);

        // Back-to-back frame_end
        hit_px(60, 60); hit_px(70, 300); hit_px(400, 300); hit_px(500, 60);
        end_frame(1'b0);
        end_frame(1'b0);

        // Reset mid-frame, then a short frame
        for (int i = 0; i < 10; i++) hit_px(40 + i, 40 + i);
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        hit_px(100, 100); hit_px(200, 200); hit_px(300, 300);
        end_frame(1'b0);
        chk("rst_x3", 80'(bus.x3), 80'd639);

        // Reset wins over frame_end in the same cycle
        for (int i = 0; i < 6; i++) hit_px(7 * i, 3 * i);
        step(1'b1, 1'b1, 9, 9, 1'b1, 1'b1, 1'b0);

        // Randomized frames
        for (int f = 0; f < 60; f++) begin
            int len;
            bit narrow;
            len = $urandom_range(0, 40);
            narrow = ($urandom % 3) == 0;
            for (int c = 0; c < len; c++) begin
                int px, py;
                if (narrow) begin
                    px = $urandom_range(0, 7) * 80;
                    py = $urandom_range(0, 7) * 60;
                end else begin
                    px = $urandom_range(0, 1023);
                    py = $urandom_range(0, 511);
                end
                step(($urandom % 97) == 0, ($urandom % 4) != 0, px, py,
                     ($urandom % 3) != 0, 1'b0, ($urandom % 2) == 1);
            end
            step(1'b0, ($urandom % 2) == 1, $urandom_range(0, 700), $urandom_range(0, 511),
                 1'b1, 1'b1, ($urandom % 8) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
